clk_div_bank: RTL and testbench

//  Bank of NUM_CH independent clock dividers driven from one system clock.

---
 rtl/clk_div_bank.sv | 80 ++++++++
 tb/tb_clk_div_bank.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// Bank of programmable clock dividers with glitch-free divisor switchover.
// Each channel emits a 50% square wave and a terminal-count strobe.
module clk_div_bank #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 17,
    parameter int DIV_INIT = 104_167,
    parameter int SEL_W    = 2
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              en,
    input  logic              resync,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_val,
    output logic              wr_err,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_INIT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt     [NUM_CH];
    logic [CNT_W-1:0] div_act [NUM_CH];
    logic [CNT_W-1:0] shadow  [NUM_CH];
    logic             wr_ok;

    always_comb begin
        wr_ok = div_wr && (div_val != '0) && (int'(div_sel) < NUM_CH);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_err  <= 1'b0;
            pending <= '0;
            tick    <= '0;
            clk_out <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]     <= '0;
                div_act[i] <= DIV_RST;
                shadow[i]  <= DIV_RST;
            end
        end else begin
            wr_err <= div_wr && !wr_ok;
            for (int i = 0; i < NUM_CH; i++) begin
                if (resync) begin
                    cnt[i]     <= '0;
                    tick[i]    <= 1'b0;
                    clk_out[i] <= 1'b0;
                    if (pending[i]) begin
                        div_act[i] <= shadow[i];
                        pending[i] <= 1'b0;
                    end
                end else if (!en) begin
                    tick[i] <= 1'b0;
                end else if (cnt[i] >= div_act[i] - ONE) begin
                    cnt[i]     <= '0;
                    tick[i]    <= 1'b1;
                    clk_out[i] <= ~clk_out[i];
                    if (pending[i]) begin
                        div_act[i] <= shadow[i];
                        pending[i] <= 1'b0;
                    end
                end else begin
                    cnt[i]  <= cnt[i] + ONE;
                    tick[i] <= 1'b0;
                end
                // Later assignment wins: a same-edge write keeps pending set
                // while the terminal/resync above consumes the old shadow.
                if (wr_ok && int'(div_sel) == i) begin
                    shadow[i]  <= div_val;
                    pending[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank against a countdown reference model.
// Directed scenarios first, then randomized traffic.
module tb_clk_div_bank;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int DINI = 4;

    logic          clk_in = 1'b0;
    logic          reset  = 1'b1;
    logic          en     = 1'b0;
    logic          resync = 1'b0;
    logic          div_wr = 1'b0;
    logic [1:0]    div_sel = '0;
    logic [CW-1:0] div_val = '0;

    logic           wr_err;
    logic [NCH-1:0] pending, tick, clk_out;
    logic           wr_err3;
    logic [2:0]     pending3, tick3, clk_out3;

    int n_tests = 0;
    int n_fail  = 0;

    int rem [NCH];
    int dv  [NCH];
    int sh  [NCH];
    bit pd  [NCH];
    bit tk  [NCH];
    bit co  [NCH];
    bit werr, werr3;

    always #5 clk_in = ~clk_in;

    clk_div_bank #(
        .NUM_CH(NCH), .CNT_W(CW), .DIV_INIT(DINI), .SEL_W(2)
    ) u_dut (
        .clk_in(clk_in), .reset(reset), .en(en), .resync(resync),
        .div_wr(div_wr), .div_sel(div_sel), .div_val(div_val),
        .wr_err(wr_err), .pending(pending), .tick(tick),
        .clk_out(clk_out)
    );

    clk_div_bank #(
        .NUM_CH(3), .CNT_W(CW), .DIV_INIT(DINI), .SEL_W(2)
    ) u_dut3 (
        .clk_in(clk_in), .reset(reset), .en(en), .resync(resync),
        .div_wr(div_wr), .div_sel(div_sel), .div_val(div_val),
        .wr_err(wr_err3), .pending(pending3), .tick(tick3),
        .clk_out(clk_out3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NCH-1:0] pack(input bit a [NCH]);
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = a[i];
        return v;
    endfunction

    // Reference: each channel counts down the cycles left until its next tick.
    task automatic model_edge(input bit r, input bit e, input bit rs,
                              input bit w, input int s, input int v);
        bit ok;
        if (r) begin
            for (int i = 0; i < NCH; i++) begin
                rem[i] = DINI; dv[i] = DINI; sh[i] = DINI;
                pd[i] = 0; tk[i] = 0; co[i] = 0;
            end
            werr = 0; werr3 = 0;
            return;
        end
        ok    = w && v != 0 && s < NCH;
        werr  = w && !ok;
        werr3 = w && (v == 0 || s >= 3);
        for (int i = 0; i < NCH; i++) begin
            if (rs) begin
                if (pd[i]) begin dv[i] = sh[i]; pd[i] = 0; end
                rem[i] = dv[i]; tk[i] = 0; co[i] = 0;
            end else if (e) begin
                rem[i] = rem[i] - 1;
                if (rem[i] <= 0) begin
                    tk[i] = 1; co[i] = !co[i];
                    if (pd[i]) begin dv[i] = sh[i]; pd[i] = 0; end
                    rem[i] = dv[i];
                end else begin
                    tk[i] = 0;
                end
            end else begin
                tk[i] = 0;
            end
            if (ok && s == i) begin sh[i] = v; pd[i] = 1; end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit rs,
                        input bit w, input int s, input int v);
        reset = r; en = e; resync = rs; div_wr = w;
        div_sel = 2'(s); div_val = CW'(v);
        @(posedge clk_in);
        model_edge(r, e, rs, w, s, v);
        #1;
        check("tick", 32'(tick), 32'(pack(tk)));
        check("clk_out", 32'(clk_out), 32'(pack(co)));
        check("pending", 32'(pending), 32'(pack(pd)));
        check("wr_err", 32'(wr_err), 32'(werr));
        check("wr_err3", 32'(wr_err3), 32'(werr3));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        // reset held 3 cycles
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0, 0, 0);
            check("rst_out", 32'({tick, clk_out, pending, wr_err}), 32'd0);
        end
        // release: first tick on 4th edge
        run(3);
        check("pre_tick", 32'(tick), 32'h0);
        run(1);
        check("first_tick", 32'(tick), 32'hF);
        check("first_clk", 32'(clk_out), 32'hF);
        run(1);
        // ch1 <- 2 while cnt = 1
        step(0, 1, 0, 1, 1, 2);
        check("wr_pend", 32'(pending), 32'h2);
        run(1);
        check("wr_pend_hold", 32'(pending), 32'h2);
        run(1);
        check("term_tick", 32'(tick), 32'hF);
        check("term_load", 32'(pending), 32'h0);
        run(2);
        check("ch1_fast", 32'(tick), 32'h2);
        run(2);
        check("all_tick", 32'(tick), 32'hF);
        // illegal writes
        step(0, 1, 0, 1, 0, 0);
        check("err_zero", 32'(wr_err), 32'd1);
        check("err_nopend", 32'(pending), 32'h0);
        step(0, 1, 0, 0, 0, 0);
        check("err_clear", 32'(wr_err), 32'd0);
        step(0, 1, 0, 1, 3, 5);
        check("err_sel3", 32'(wr_err3), 32'd1);
        check("ok_sel3", 32'(wr_err), 32'd0);
        check("nopend3", 32'(pending3), 32'h0);
        run(3);
        // en low 5 cycles
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0, 0, 0);
            check("en_off_tick", 32'(tick), 32'h0);
        end
        run(7);
        // ch2 <- 6, then resync with ch3 <- 5 on same edge
        step(0, 1, 0, 1, 2, 6);
        step(0, 1, 1, 1, 3, 5);
        check("rs_clk", 32'(clk_out), 32'h0);
        check("rs_pend", 32'(pending), 32'h8);
        run(5);
        check("rs_ch2_early", 32'(tick[2]), 32'd0);
        run(1);
        check("rs_ch2_tick", 32'(tick[2]), 32'd1);
        run(3);
        // reset while ch0 pending and clk_out[0] high
        for (int k = 0; k < 20 && !co[0]; k++) run(1);
        step(0, 1, 0, 1, 0, 3);
        check("pre_rst_pend", 32'(pending[0]), 32'd1);
        step(1, 1, 0, 0, 0, 0);
        check("mid_rst", 32'({tick, clk_out, pending, wr_err}), 32'd0);
        run(3);
        check("rst_div_pre", 32'(tick), 32'h0);
        run(1);
        check("rst_div", 32'(tick), 32'hF);
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 7) != 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 9)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
